rs_age_sched: RTL

RS_AGE_SCHED -- requirements
Module: rs_age_sched

---
 rtl/rs_age_sched.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rs_age_sched.sv
// ============================================================================
// Module   : rs_age_sched
// Brief    : Age-ordered reservation station with wakeup, issue and flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rs_age_sched_pkg;
  // Field widths used by the packed entry types
  localparam int c_PREG_W = 7;
  localparam int c_ROB_W  = 5;

  typedef struct packed {
    logic [31:0]         pc;
    logic [1:0]          fu;
    logic [6:0]          opcode;
    logic [c_PREG_W-1:0] pd_new;
    logic [c_PREG_W-1:0] ps1;
    logic [c_PREG_W-1:0] ps2;
    logic [31:0]         imm;
    logic [2:0]          func3;
    logic [6:0]          func7;
  } rename_data;

  typedef struct packed {
    logic                valid;
    logic [31:0]         pc;
    logic [1:0]          fu;
    logic [6:0]          opcode;
    logic [c_PREG_W-1:0] pd;
    logic [c_PREG_W-1:0] ps1;
    logic                ps1_ready;
    logic [c_PREG_W-1:0] ps2;
    logic                ps2_ready;
    logic [31:0]         imm;
    logic [2:0]          func3;
    logic [6:0]          func7;
    logic [c_ROB_W-1:0]  rob_index;
  } rs_data;
endpackage

module rs_age_sched
  import rs_age_sched_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PREG_W   = 7,
  parameter int ROB_W    = 5,
  parameter int WB_PORTS = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             di_en,
  input  rename_data                       r_data,
  input  logic [ROB_W-1:0]                 rob_index_in,
  input  logic [2**PREG_W-1:0]             preg_rtable,
  input  logic [WB_PORTS-1:0]              wb_valid,
  input  logic [WB_PORTS-1:0][PREG_W-1:0]  wb_tag,
  input  logic                             fu_ready,
  input  logic [ROB_W-1:0]                 rob_head,
  input  logic                             mispredict,
  input  logic [ROB_W-1:0]                 mispredict_tag,
  output logic                             fu_issued,
  output logic                             full,
  output rs_data                           data_out,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_IDX_W + 1;

  rs_data               r_ent [DEPTH];
  rs_data               r_data_out;
  logic                 r_issued;

  logic [ROB_W-1:0]     w_age [DEPTH];
  logic [ROB_W-1:0]     w_br_age;
  logic [DEPTH-1:0]     w_valid;
  logic [DEPTH-1:0]     w_issuable;
  logic [DEPTH-1:0]     w_flush;
  logic                 w_sel_found;
  logic [c_IDX_W-1:0]   w_sel_idx;
  logic [ROB_W-1:0]     w_sel_age;
  logic                 w_free_found;
  logic [c_IDX_W-1:0]   w_free_idx;
  logic [c_CNT_W-1:0]   w_count;
  logic                 w_full;
  logic                 w_issue;
  logic                 w_alloc;
  rs_data               w_new;

  // A source is ready if the table says so, a writeback is broadcasting it, or it is p0
  function automatic logic f_src_ready(input logic [PREG_W-1:0] tag);
    logic rdy;
    rdy = (tag == '0) || preg_rtable[tag];
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_valid[k] && (wb_tag[k] == tag)) rdy = 1'b1;
    end
    return rdy;
  endfunction

  always_comb begin
    w_br_age = mispredict_tag - rob_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_age[i]      = ROB_W'(r_ent[i].rob_index) - rob_head;
      w_valid[i]    = r_ent[i].valid;
      w_issuable[i] = r_ent[i].valid && r_ent[i].ps1_ready && r_ent[i].ps2_ready;
      w_flush[i]    = mispredict && r_ent[i].valid && (w_age[i] > w_br_age);
    end
  end

  // Oldest issuable entry; strict compare keeps the lowest index on ties
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sel_age   = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_issuable[i] && (!w_sel_found || (w_age[i] < w_sel_age))) begin
        w_sel_found = 1'b1;
        w_sel_idx   = c_IDX_W'(i);
        w_sel_age   = w_age[i];
      end
    end
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_count      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_valid[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = c_IDX_W'(i);
      end
      w_count = w_count + c_CNT_W'(w_valid[i]);
    end
  end

  assign w_full  = &w_valid;
  assign w_issue = fu_ready && w_sel_found && !w_flush[w_sel_idx];
  assign w_alloc = di_en && !w_full && !mispredict;

  always_comb begin
    w_new           = '0;
    w_new.valid     = 1'b1;
    w_new.pc        = r_data.pc;
    w_new.fu        = r_data.fu;
    w_new.opcode    = r_data.opcode;
    w_new.pd        = r_data.pd_new;
    w_new.ps1       = r_data.ps1;
    w_new.ps1_ready = f_src_ready(PREG_W'(r_data.ps1));
    w_new.ps2       = r_data.ps2;
    w_new.ps2_ready = f_src_ready(PREG_W'(r_data.ps2));
    w_new.imm       = r_data.imm;
    w_new.func3     = r_data.func3;
    w_new.func7     = r_data.func7;
    w_new.rob_index = c_ROB_W'(rob_index_in);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_data_out <= '0;
      r_issued   <= 1'b0;
    end else begin
      r_issued <= w_issue;
      if (w_issue) r_data_out <= r_ent[w_sel_idx];
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc && (w_free_idx == c_IDX_W'(i))) begin
          r_ent[i] <= w_new;
        end else if (w_flush[i] || (w_issue && (w_sel_idx == c_IDX_W'(i)))) begin
          r_ent[i] <= '0;
        end else if (r_ent[i].valid) begin
          if (f_src_ready(PREG_W'(r_ent[i].ps1))) r_ent[i].ps1_ready <= 1'b1;
          if (f_src_ready(PREG_W'(r_ent[i].ps2))) r_ent[i].ps2_ready <= 1'b1;
        end
      end
    end
  end

  assign fu_issued = r_issued;
  assign data_out  = r_data_out;
  assign count     = w_count;
  assign full      = w_full;

endmodule

`default_nettype wire
